display_controller: RTL and testbench
=====================================

# display_controller

Raster timing generator for the 640x480 VGA display. Divides the system clock into a pixel-rate enable and runs horizontal and vertical scan counters. Produces sync, blanking and frame/line strobes. Its hCount/vCount outputs are the scan coordinates that every sprite and pipe renderer consumes combinationally to decide its pixel.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel; must be ≥1. At 100 MHz this gives a 25 MHz pixel rate.
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal region lengths in pixels. Total is 800.
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical region lengths in lines. Total is 525.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hCount  out  10  current pixel column, 0..799.
- vCount  out  10  current line, 0..524.
- hSync  out  1  horizontal sync, active low.
- vSync  out  1  vertical sync, active low.
- bright  out  1  high when the current pixel is in the visible area.
- pix_tick  out  1  one-clk pulse each time a new pixel is presented.
- line_start  out  1  one-clk pulse when hCount becomes 0.
- frame_start  out  1  one-clk pulse when (hCount,vCount) becomes (0,0).
- frame_count  out  16  frame counter. Present only with DISPLAY_FRAME_CNT_EN.

## Operation
- Divider:
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - An "advance" occurs on the edge where div==CLK_DIV-1 before the edge.
  - With CLK_DIV=1, every edge is an advance.
- Horizontal axis, on each advance:
  - hCount increments; 799 wraps to 0.
  - The phase state machine steps ACTIVE(0..639) -> FRONT(640..655) -> SYNC(656..751) -> BACK(752..799) -> ACTIVE.
- Vertical axis:
  - Advances only on a horizontal wrap (799->0).
  - vCount increments; 524 wraps to 0.
  - Phases are ACTIVE(0..479) -> FRONT(480..489) -> SYNC(490..491) -> BACK(492..524) -> ACTIVE.
- Outputs:
  - hSync=0 exactly while the horizontal phase is SYNC.
  - vSync=0 exactly while the vertical phase is SYNC.
  - bright=1 when both phases are ACTIVE.
- Strobes:
  - line_start and frame_start are qualified by the same advance as pix_tick.
  - On a frame wrap, line_start and frame_start are both high in the same cycle.
- Arithmetic: all counters wrap by explicit compare against total-1, never by natural overflow.
- Phase boundaries are computed from the parameters: FRONT starts at VISIBLE, SYNC at VISIBLE+FRONT, BACK at VISIBLE+FRONT+SYNC.

## Timing
- Reset values:
  - div=0, hCount=0, vCount=0.
  - hSync=1, vSync=1, bright=1.
  - pix_tick=0, line_start=0, frame_start=0.
  - frame_count=0.
  - Both phase FSMs are in ACTIVE.
- First advance is on the CLK_DIV-th edge after reset deasserts.
- All outputs are registered and update on the advance edge. hSync, vSync and bright always describe the hCount/vCount values visible in the same cycle, with zero lag.
- pix_tick is high in the single cycle following each advance edge. It is constant 1 when CLK_DIV=1, except in the first cycle after reset.
- hCount and vCount hold steady for CLK_DIV clocks between advances.
- Reset asserted mid-frame restores all reset values on that edge, regardless of div or phase.

## Configuration
- DISPLAY_FRAME_CNT_EN defined:
  - The frame_count port exists.
  - It increments by 1 on every frame wrap and wraps 0xFFFF->0.
  - Reset clears it to 0.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package display_pkg holds:
  - the default timing constants (H_/V_ visible, front, sync, back and totals), and the 10-bit coordinate width;
  - the phase enum typedef scan_phase_t {ACTIVE, FRONT, SYNC, BACK}.
- Sub-module scan_axis_counter:
  - Parameterised by region lengths.
  - Inputs: step. Outputs: count, phase, wrap.
  - Instantiated twice. The vertical instance's step is the horizontal instance's wrap ANDed with advance.

## Test plan
- Reset, then release; hold CLK_DIV=4 -> all reset values seen; first pix_tick is 4 clks after release; hCount=1 in that cycle.
- Run one line -> hSync is low for exactly 96 consecutive pixels, hCount 656..751; bright falls when hCount=640.
- Line wrap at hCount=799 -> next pixel has hCount=0, vCount=1, line_start=1 for one clk, frame_start=0.
- Frame wrap from (799,524) -> (0,0) with line_start=frame_start=1 in the same cycle. vSync is low only on lines 490..491. There are 420000 pixels per frame.
- Assert reset at (300,200) mid-pixel -> the next cycle shows (0,0), hSync=vSync=1, pix_tick=0; the sequence then restarts as in scenario 1.
- With DISPLAY_FRAME_CNT_EN, run 3 frames -> frame_count reads 1, 2, 3 coincident with each frame_start. Separately, CLK_DIV=1 gives pix_tick high every cycle.

Source files
------------

// File: rtl/display_controller_pkg.sv
`default_nettype none
// =============================================================================
// Module      : display_pkg
// Description : Default 640x480 VGA timing constants and the scan phase type.
// Revision    : 1.0
// =============================================================================
package display_pkg;

    localparam int COORD_W = 10;

    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_H_TOTAL   = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;

    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;
    localparam int C_V_TOTAL   = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } scan_phase_t;

endpackage
`default_nettype wire

// File: rtl/display_controller_if.sv
`default_nettype none
// =============================================================================
// Module      : display_controller_if
// Description : Raster coordinate, sync and strobe bundle from the timing
//               generator to its consumers. frame_count needs
//               DISPLAY_FRAME_CNT_EN.
// Revision    : 1.0
// =============================================================================
interface display_controller_if;
    import display_pkg::*;

    logic [COORD_W-1:0] hCount;
    logic [COORD_W-1:0] vCount;
    logic               hSync;
    logic               vSync;
    logic               bright;
    logic               pix_tick;
    logic               line_start;
    logic               frame_start;
`ifdef DISPLAY_FRAME_CNT_EN
    logic [15:0]        frame_count;
`endif

    modport master (
`ifdef DISPLAY_FRAME_CNT_EN
        output frame_count,
`endif
        output hCount, vCount, hSync, vSync, bright,
        output pix_tick, line_start, frame_start
    );

    modport slave (
`ifdef DISPLAY_FRAME_CNT_EN
        input frame_count,
`endif
        input hCount, vCount, hSync, vSync, bright,
        input pix_tick, line_start, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/display_controller_scan_axis_counter.sv
`default_nettype none
// =============================================================================
// Module      : scan_axis_counter
// Description : One scan axis: position counter plus ACTIVE/FRONT/SYNC/BACK
//               phase FSM, stepping only when step is high.
// Revision    : 1.0
// =============================================================================
module scan_axis_counter
    import display_pkg::*;
#(
    parameter int LEN_VISIBLE = 640,
    parameter int LEN_FRONT   = 16,
    parameter int LEN_SYNC    = 96,
    parameter int LEN_BACK    = 48
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               step,
    output logic [COORD_W-1:0]      count,
    output scan_phase_t             phase,
    output logic                    wrap
);

    localparam int TOTAL = LEN_VISIBLE + LEN_FRONT + LEN_SYNC + LEN_BACK;
    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] END_ACTIVE = COORD_W'(LEN_VISIBLE - 1);
    localparam logic [COORD_W-1:0] END_FRONT  = COORD_W'(LEN_VISIBLE + LEN_FRONT - 1);
    localparam logic [COORD_W-1:0] END_SYNC   = COORD_W'(LEN_VISIBLE + LEN_FRONT + LEN_SYNC - 1);
    localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);

    logic [COORD_W-1:0] count_q, count_d;
    scan_phase_t        phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    // Phase moves on the step that leaves the last position of its region.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + ONE;
            case (phase_q)
                ACTIVE:  if (count_q == END_ACTIVE) phase_d = FRONT;
                FRONT:   if (count_q == END_FRONT)  phase_d = SYNC;
                SYNC:    if (count_q == END_SYNC)   phase_d = BACK;
                BACK:    if (count_q == LAST)       phase_d = ACTIVE;
                default: phase_d = ACTIVE;
            endcase
        end
    end

    always_comb begin
        count = count_q;
        phase = phase_q;
        wrap  = (count_q == LAST);
    end

endmodule
`default_nettype wire

// File: rtl/display_controller.sv
`default_nettype none
// =============================================================================
// Module      : display_controller
// Description : VGA raster timing generator. Optional frame counter is
//               enabled by defining DISPLAY_FRAME_CNT_EN.
// Revision    : 1.0
// =============================================================================
module display_controller
    import display_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = C_H_VISIBLE,
    parameter int H_FRONT   = C_H_FRONT,
    parameter int H_SYNC    = C_H_SYNC,
    parameter int H_BACK    = C_H_BACK,
    parameter int V_VISIBLE = C_V_VISIBLE,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK
) (
    input  wire logic              clk,
    input  wire logic              reset,
    display_controller_if.master   disp
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               advance, v_step;
    logic               h_wrap, v_wrap;
    logic [COORD_W-1:0] h_count, v_count;
    scan_phase_t        h_phase, v_phase;
    logic               pix_tick_q, pix_tick_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    always_comb begin
        advance       = (div_q == DIV_LAST);
        div_d         = advance ? '0 : div_q + DIV_ONE;
        v_step        = advance & h_wrap;
        pix_tick_d    = advance;
        line_start_d  = v_step;
        frame_start_d = v_step & v_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    scan_axis_counter #(
        .LEN_VISIBLE (H_VISIBLE),
        .LEN_FRONT   (H_FRONT),
        .LEN_SYNC    (H_SYNC),
        .LEN_BACK    (H_BACK)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .step  (advance),
        .count (h_count),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    scan_axis_counter #(
        .LEN_VISIBLE (V_VISIBLE),
        .LEN_FRONT   (V_FRONT),
        .LEN_SYNC    (V_SYNC),
        .LEN_BACK    (V_BACK)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .step  (v_step),
        .count (v_count),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

`ifdef DISPLAY_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start_d)
            frame_count_d = (frame_count_q == 16'hFFFF) ? 16'h0000 : frame_count_q + 16'h0001;
    end

    always_ff @(posedge clk) begin
        if (reset) frame_count_q <= 16'h0000;
        else       frame_count_q <= frame_count_d;
    end

    assign disp.frame_count = frame_count_q;
`endif

    // Sync/bright decode straight from the phase flops so they track the counts with no lag.
    assign disp.hCount      = h_count;
    assign disp.vCount      = v_count;
    assign disp.hSync       = (h_phase != SYNC);
    assign disp.vSync       = (v_phase != SYNC);
    assign disp.bright      = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign disp.pix_tick    = pix_tick_q;
    assign disp.line_start  = line_start_q;
    assign disp.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_display_controller.sv
`default_nettype none
// =============================================================================
// Module      : tb_display_controller
// Description : Directed checks of the raster generator: full-size timing at
//               CLK_DIV=4 and a short 8-line frame at CLK_DIV=1.
// Revision    : 1.0
// =============================================================================
module tb_display_controller;
    import display_pkg::*;

    logic clk = 1'b0;
    logic reset0 = 1'b1;
    logic reset1 = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    display_controller_if if0();
    display_controller_if if1();

    display_controller #(.CLK_DIV(4)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .disp  (if0)
    );

    display_controller #(
        .CLK_DIV   (1),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset1),
        .disp  (if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_pixel0(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!if0.pix_tick && gap < 16);
        if (!if0.pix_tick) begin
            checks++; failures++;
            $display("FAIL pix_timeout got no pix_tick in %0d clks, required within 4", gap);
        end
    endtask

    task automatic test_reset();
        logic [25:0] got;
        int n;
        reset0 = 1'b1;
        repeat (3) tick();
        got = {if0.hCount, if0.vCount, if0.hSync, if0.vSync, if0.bright,
               if0.pix_tick, if0.line_start, if0.frame_start};
        checks++;
        if (got !== {10'd0, 10'd0, 6'b111000}) begin
            failures++;
            $display("FAIL reset_state got=%h required=%h", got, {10'd0, 10'd0, 6'b111000});
        end
`ifdef DISPLAY_FRAME_CNT_EN
        checks++;
        if (if0.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_count got=%0d required=0", if0.frame_count);
        end
`endif
        reset0 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if0.pix_tick && n < 16);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL first_pix_latency got=%0d required=4", n);
        end
        checks++;
        if (if0.hCount !== 10'd1 || if0.vCount !== 10'd0) begin
            failures++;
            $display("FAIL first_pix_coord got=(%0d,%0d) required=(1,0)", if0.hCount, if0.vCount);
        end
    endtask

    task automatic test_line();
        int gap, bad_gap, low, first_low, last_low, first_dark, prev_h, early_ls;
        bad_gap = 0; low = 0; first_low = -1; last_low = -1; first_dark = -1;
        prev_h = 1; early_ls = 0;
        for (int i = 0; i < 1000; i++) begin
            next_pixel0(gap);
            if (gap != 4) bad_gap++;
            if (if0.hCount == 10'd0) break;
            if (if0.line_start) early_ls++;
            if (!if0.hSync) begin
                low++;
                if (first_low < 0) first_low = int'(if0.hCount);
                last_low = int'(if0.hCount);
            end
            if (!if0.bright && first_dark < 0) first_dark = int'(if0.hCount);
            prev_h = int'(if0.hCount);
        end
        checks++;
        if (bad_gap !== 0) begin
            failures++;
            $display("FAIL pixel_hold got=%0d bad gaps required=0", bad_gap);
        end
        checks++;
        if (low !== 96 || first_low !== 656 || last_low !== 751) begin
            failures++;
            $display("FAIL hsync_window got=%0d px %0d..%0d required=96 px 656..751",
                     low, first_low, last_low);
        end
        checks++;
        if (first_dark !== 640) begin
            failures++;
            $display("FAIL bright_fall got=%0d required=640", first_dark);
        end
        checks++;
        if (prev_h !== 799 || early_ls !== 0) begin
            failures++;
            $display("FAIL line_end got last_h=%0d early_ls=%0d required 799,0", prev_h, early_ls);
        end
        checks++;
        if (if0.hCount !== 10'd0 || if0.vCount !== 10'd1 ||
            if0.line_start !== 1'b1 || if0.frame_start !== 1'b0) begin
            failures++;
            $display("FAIL line_wrap got=(%0d,%0d) ls=%b fs=%b required=(0,1) ls=1 fs=0",
                     if0.hCount, if0.vCount, if0.line_start, if0.frame_start);
        end
        tick();
        checks++;
        if (if0.line_start !== 1'b0 || if0.hCount !== 10'd0) begin
            failures++;
            $display("FAIL line_start_width got ls=%b h=%0d required ls=0 h=0",
                     if0.line_start, if0.hCount);
        end
    endtask

    task automatic test_mid_reset();
        int gap, n;
        for (int i = 0; i < 400; i++) begin
            next_pixel0(gap);
            if (if0.hCount == 10'd300) break;
        end
        tick();
        tick();
        reset0 = 1'b1;
        tick();
        checks++;
        if (if0.hCount !== 10'd0 || if0.vCount !== 10'd0 || if0.hSync !== 1'b1 ||
            if0.vSync !== 1'b1 || if0.bright !== 1'b1 || if0.pix_tick !== 1'b0 ||
            if0.line_start !== 1'b0 || if0.frame_start !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=(%0d,%0d) hs=%b vs=%b br=%b pt=%b required=(0,0) 1 1 1 0",
                     if0.hCount, if0.vCount, if0.hSync, if0.vSync, if0.bright, if0.pix_tick);
        end
        reset0 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if0.pix_tick && n < 16);
        checks++;
        if (n !== 4 || if0.hCount !== 10'd1) begin
            failures++;
            $display("FAIL restart got latency=%0d h=%0d required latency=4 h=1", n, if0.hCount);
        end
    endtask

    task automatic test_frame_small();
        int no_tick, fs, fs_bad, prev_bad, period_bad, br_bad, hs_bad, ls_cnt, fc_bad;
        int since, prev_h, prev_v;
        logic [7:0] vs_lines;
        logic exp_b, exp_hs;
        no_tick = 0; fs = 0; fs_bad = 0; prev_bad = 0; period_bad = 0;
        br_bad = 0; hs_bad = 0; ls_cnt = 0; fc_bad = 0; since = 0;
        prev_h = 0; prev_v = 0; vs_lines = 8'h00;
        reset1 = 1'b1;
        tick();
        checks++;
        if (if1.pix_tick !== 1'b0) begin
            failures++;
            $display("FAIL div1_reset_tick got=%b required=0", if1.pix_tick);
        end
        reset1 = 1'b0;
        for (int c = 0; c < 3 * 6400 + 100; c++) begin
            tick();
            since++;
            if (!if1.pix_tick) no_tick++;
            if (if1.line_start) ls_cnt++;
            if (!if1.vSync && if1.vCount < 10'd8) vs_lines[if1.vCount[2:0]] = 1'b1;
            exp_b  = (if1.hCount < 10'd640) && (if1.vCount < 10'd4);
            exp_hs = !((if1.hCount >= 10'd656) && (if1.hCount <= 10'd751));
            if (if1.bright !== exp_b)  br_bad++;
            if (if1.hSync  !== exp_hs) hs_bad++;
            if (if1.frame_start) begin
                fs++;
                if (if1.hCount !== 10'd0 || if1.vCount !== 10'd0 || !if1.line_start) fs_bad++;
                if (prev_h != 799 || prev_v != 7) prev_bad++;
                if (since != 6400) period_bad++;
`ifdef DISPLAY_FRAME_CNT_EN
                if (int'(if1.frame_count) != fs) fc_bad++;
`endif
                since = 0;
            end
            prev_h = int'(if1.hCount);
            prev_v = int'(if1.vCount);
            if (fs == 3) break;
        end
        checks++;
        if (no_tick !== 0) begin
            failures++;
            $display("FAIL div1_pix_tick got=%0d idle cycles required=0", no_tick);
        end
        checks++;
        if (fs !== 3 || ls_cnt !== 24) begin
            failures++;
            $display("FAIL frame_count_run got frames=%0d lines=%0d required 3,24", fs, ls_cnt);
        end
        checks++;
        if (fs_bad !== 0 || prev_bad !== 0) begin
            failures++;
            $display("FAIL frame_wrap got bad_at=%0d bad_before=%0d required 0,0", fs_bad, prev_bad);
        end
        checks++;
        if (period_bad !== 0) begin
            failures++;
            $display("FAIL frame_period got=%0d bad frames required=0 (6400 px each)", period_bad);
        end
        checks++;
        if (vs_lines !== 8'b0110_0000) begin
            failures++;
            $display("FAIL vsync_lines got=%b required=01100000", vs_lines);
        end
        checks++;
        if (br_bad !== 0 || hs_bad !== 0) begin
            failures++;
            $display("FAIL div1_decode got bright_err=%0d hsync_err=%0d required 0,0", br_bad, hs_bad);
        end
`ifdef DISPLAY_FRAME_CNT_EN
        checks++;
        if (fc_bad !== 0 || if1.frame_count !== 16'd3) begin
            failures++;
            $display("FAIL frame_counter got bad=%0d final=%0d required 0,3", fc_bad, if1.frame_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_frame_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
